// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-side signals of the two-port memory bus arbiter.
// slave: the arbiter itself; master: the requesters and memory that surround it.
interface mem_bus_arbiter_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic        data_req;
  logic        data_rw;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic [31:0] rdata;
  logic        err;
  logic        mem_req;
  logic [31:0] address_bus;
  logic [31:0] data_bus;
  logic        rw;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, data_req, data_rw, data_addr, data_wdata, mem_ready, mem_rdata,
    output fetch_ack, data_ack, rdata, err, mem_req, address_bus, data_bus, rw
  );

  modport master (
    output fetch_req, fetch_addr, data_req, data_rw, data_addr, data_wdata, mem_ready, mem_rdata,
    input  fetch_ack, data_ack, rdata, err, mem_req, address_bus, data_bus, rw
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the external memory bus between fetch and data ports, with a hung-access timeout.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise data has fixed priority.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst_n,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle = 2'd0, StBusy = 2'd1, StDone = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic        mem_req_q, mem_req_d;
  logic        err_q, err_d;
  logic        owner_q, owner_d;  // 1 = data port
  logic        fetch_ack_q, fetch_ack_d;
  logic        data_ack_q, data_ack_d;
  logic        grant_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;  // 1 = data port owned the last grant
  assign grant_data = bus.data_req & (~bus.fetch_req | ~last_q);
`else
  assign grant_data = bus.data_req;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    mem_req_d   = mem_req_q;
    err_d       = err_q;
    owner_d     = owner_q;
    fetch_ack_d = 1'b0;
    data_ack_d  = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.fetch_req || bus.data_req) begin
          owner_d   = grant_data;
          addr_d    = grant_data ? bus.data_addr : bus.fetch_addr;
          wdata_d   = grant_data ? bus.data_wdata : 32'h0;
          rw_d      = grant_data ? bus.data_rw : 1'b1;
          cnt_d     = 8'h0;
          mem_req_d = 1'b1;
          state_d   = StBusy;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d    = grant_data;
`endif
        end
      end
      StBusy: begin
        // mem_ready takes precedence over a timeout on the same edge
        if (bus.mem_ready) begin
          rdata_d     = rw_q ? bus.mem_rdata : 32'h0;
          err_d       = 1'b0;
          mem_req_d   = 1'b0;
          fetch_ack_d = ~owner_q;
          data_ack_d  = owner_q;
          state_d     = StDone;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          rdata_d     = 32'hDEADBEEF;
          err_d       = 1'b1;
          mem_req_d   = 1'b0;
          fetch_ack_d = ~owner_q;
          data_ack_d  = owner_q;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end
      StDone: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      cnt_q       <= 8'h0;
      rw_q        <= 1'b0;
      mem_req_q   <= 1'b0;
      err_q       <= 1'b0;
      owner_q     <= 1'b0;
      fetch_ack_q <= 1'b0;
      data_ack_q  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      mem_req_q   <= mem_req_d;
      err_q       <= err_d;
      owner_q     <= owner_d;
      fetch_ack_q <= fetch_ack_d;
      data_ack_q  <= data_ack_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  assign bus.fetch_ack   = fetch_ack_q;
  assign bus.data_ack    = data_ack_q;
  assign bus.rdata       = rdata_q;
  assign bus.err         = err_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.address_bus = addr_q;
  assign bus.data_bus    = wdata_q;
  assign bus.rw          = rw_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, transaction-level random model,
// and hand sequences for contention, reset mid-access and idle mem_ready.
module tb_mem_bus_arbiter;
  localparam int unsigned Tmo = 4;

  logic clk = 1'b0;
  logic rst_n;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(.TIMEOUT(Tmo)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        freq, dreq, drw;
    logic [31:0] faddr, daddr, wdata, mrdata;
    int          lat;      // busy cycle on whose closing edge mem_ready is high; 0 = never
    logic        e_data;   // expected winner is the data port
    logic [31:0] e_addr, e_wbus;
    logic        e_rw;
    int          e_cyc;    // edges from grant to ack
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  logic last_data = 1'b0;  // model: last grant went to the data port

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic freq, dreq, drw, input logic [31:0] faddr, daddr,
                              wdata, mrdata, input int lat, input logic e_data,
                              input logic [31:0] e_addr, e_wbus, input logic e_rw,
                              input int e_cyc, input logic [31:0] e_rdata, input logic e_err);
    vec_t v;
    v.freq = freq; v.dreq = dreq; v.drw = drw; v.faddr = faddr; v.daddr = daddr;
    v.wdata = wdata; v.mrdata = mrdata; v.lat = lat; v.e_data = e_data; v.e_addr = e_addr;
    v.e_wbus = e_wbus; v.e_rw = e_rw; v.e_cyc = e_cyc; v.e_rdata = e_rdata; v.e_err = e_err;
    return v;
  endfunction

  // Transaction-level reference: winner from the arbitration rule, latency = min(ready, timeout)
  function automatic vec_t model(input vec_t v);
    vec_t e;
    logic pick, tmo;
    e = v;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    pick = v.dreq && (!v.freq || !last_data);
`else
    pick = v.dreq;
`endif
    tmo       = (v.lat == 0) || (v.lat > int'(Tmo));
    e.e_data  = pick;
    e.e_addr  = pick ? v.daddr : v.faddr;
    e.e_wbus  = pick ? v.wdata : 32'h0;
    e.e_rw    = pick ? v.drw : 1'b1;
    e.e_cyc   = tmo ? int'(Tmo) : v.lat;
    e.e_err   = tmo;
    e.e_rdata = tmo ? 32'hDEADBEEF : (e.e_rw ? v.mrdata : 32'h0);
    return e;
  endfunction

  task automatic idle_inputs();
    bus.fetch_req = 0; bus.fetch_addr = 0; bus.data_req = 0; bus.data_rw = 0;
    bus.data_addr = 0; bus.data_wdata = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".ctl"}, 32'({bus.fetch_ack, bus.data_ack, bus.err, bus.mem_req, bus.rw}), 32'h0);
    chk({tag, ".addr"}, bus.address_bus, 32'h0);
    chk({tag, ".wbus"}, bus.data_bus, 32'h0);
    chk({tag, ".rdata"}, bus.rdata, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    last_data = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int   c;
    logic seen, frozen;
    @(negedge clk);
    bus.fetch_req = v.freq; bus.fetch_addr = v.faddr; bus.data_req = v.dreq;
    bus.data_rw = v.drw; bus.data_addr = v.daddr; bus.data_wdata = v.wdata;
    bus.mem_rdata = v.mrdata;
    @(posedge clk); @(negedge clk);
    chk({tag, ".memreq"}, 32'(bus.mem_req), 32'h1);
    chk({tag, ".addr"}, bus.address_bus, v.e_addr);
    chk({tag, ".wbus"}, bus.data_bus, v.e_wbus);
    chk({tag, ".rw"}, 32'(bus.rw), 32'(v.e_rw));
    seen = 0; frozen = 1; c = 0;
    while (!seen && c < 64) begin
      c++;
      bus.mem_ready = (v.lat == c);
      // requester fields change after grant and must not reach the bus
      bus.fetch_addr = $urandom; bus.data_addr = $urandom; bus.data_wdata = $urandom;
      bus.data_rw = 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk);
      bus.mem_ready = 0;
      if (bus.fetch_ack || bus.data_ack) seen = 1;
      else if (!bus.mem_req || bus.address_bus !== v.e_addr || bus.data_bus !== v.e_wbus ||
               bus.rw !== v.e_rw) frozen = 0;
    end
    chk({tag, ".frozen"}, 32'(frozen), 32'h1);
    chk({tag, ".cycles"}, c, v.e_cyc);
    chk({tag, ".acks"}, 32'({bus.fetch_ack, bus.data_ack}), v.e_data ? 32'h1 : 32'h2);
    chk({tag, ".rdata"}, bus.rdata, v.e_rdata);
    chk({tag, ".err"}, 32'(bus.err), 32'(v.e_err));
    chk({tag, ".memreq_done"}, 32'(bus.mem_req), 32'h0);
    bus.fetch_req = 0; bus.data_req = 0;
    @(posedge clk); @(negedge clk);
    chk({tag, ".ack_pulse"}, 32'({bus.fetch_ack, bus.data_ack}), 32'h0);
    last_data = v.e_data;
  endtask

  vec_t tbl[6];
  vec_t rv;
  logic exp_order[4];
  int   gap;

  initial begin
    idle_inputs();
    rst_n = 0;
    tbl[0] = mk(1, 0, 0, 32'h40, 0, 0, 32'hE3A01005, 2,
                0, 32'h40, 32'h0, 1, 2, 32'hE3A01005, 0);
    tbl[1] = mk(0, 1, 0, 0, 32'h12345678, 32'h9ABCDEF0, 32'h55555555, 1,
                1, 32'h12345678, 32'h9ABCDEF0, 0, 1, 32'h0, 0);
    tbl[2] = mk(0, 1, 1, 0, 32'h1000, 32'h11111111, 32'hCAFEF00D, 3,
                1, 32'h1000, 32'h11111111, 1, 3, 32'hCAFEF00D, 0);
    tbl[3] = mk(1, 0, 0, 32'h200, 0, 0, 32'h77777777, 0,
                0, 32'h200, 32'h0, 1, 4, 32'hDEADBEEF, 1);
    tbl[4] = mk(1, 0, 0, 32'h300, 0, 0, 32'h0BADF00D, 4,
                0, 32'h300, 32'h0, 1, 4, 32'h0BADF00D, 0);
    tbl[5] = mk(0, 1, 0, 0, 32'h400, 32'hA5A5A5A5, 32'h1, 0,
                1, 32'h400, 32'hA5A5A5A5, 0, 4, 32'hDEADBEEF, 1);

    do_reset();
    check_cleared("reset");

    for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // mem_ready while idle must produce nothing
    @(negedge clk);
    bus.mem_ready = 1;
    repeat (2) @(negedge clk);
    bus.mem_ready = 0;
    chk("idle_ready", 32'({bus.fetch_ack, bus.data_ack, bus.mem_req}), 32'h0);

    for (int i = 0; i < 40; i++) begin
      rv.freq = 1'($urandom_range(0, 1)); rv.dreq = 1'($urandom_range(0, 1));
      if (!rv.freq && !rv.dreq) rv.freq = 1;
      rv.drw = 1'($urandom_range(0, 1));
      rv.faddr = $urandom; rv.daddr = $urandom; rv.wdata = $urandom; rv.mrdata = $urandom;
      rv.lat = int'($urandom_range(0, 6));
      run_txn(model(rv), $sformatf("rand%0d", i));
    end

    // Contention: both requests held continuously
    do_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    bus.fetch_req = 1; bus.fetch_addr = 32'hF0; bus.data_req = 1; bus.data_rw = 1;
    bus.data_addr = 32'hD0; bus.mem_rdata = 32'h1234;
    for (int k = 0; k < 4; k++) begin
      gap = 0;
      while (!bus.mem_req && gap < 10) begin
        @(posedge clk); @(negedge clk);
        gap++;
      end
      chk($sformatf("cont%0d.gap", k), gap, (k == 0) ? 1 : 2);
      chk($sformatf("cont%0d.owner", k), bus.address_bus, exp_order[k] ? 32'hD0 : 32'hF0);
      bus.mem_ready = 1;
      @(posedge clk); @(negedge clk);
      bus.mem_ready = 0;
      chk($sformatf("cont%0d.ack", k), 32'({bus.fetch_ack, bus.data_ack}),
          exp_order[k] ? 32'h1 : 32'h2);
    end
    bus.fetch_req = 0; bus.data_req = 0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a busy access
    bus.fetch_req = 1; bus.fetch_addr = 32'h80; bus.mem_rdata = 32'h600DCAFE;
    @(posedge clk); @(negedge clk);
    chk("rst_mid.granted", 32'(bus.mem_req), 32'h1);
    @(posedge clk); @(negedge clk);
    rst_n = 0;
    @(posedge clk); @(negedge clk);
    check_cleared("rst_mid");
    rst_n = 1;
    last_data = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_mid.regrant", 32'(bus.mem_req), 32'h1);
    chk("rst_mid.addr", bus.address_bus, 32'h80);
    bus.mem_ready = 1;
    @(posedge clk); @(negedge clk);
    bus.mem_ready = 0;
    chk("rst_mid.ack", 32'({bus.fetch_ack, bus.data_ack}), 32'h2);
    chk("rst_mid.rdata", bus.rdata, 32'h600DCAFE);
    bus.fetch_req = 0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequences the single external memory bus between two requesters: the instruction-fetch port and the load/store data port fed by `MemoryController`. A level request/ack handshake is used on each port. It drives `AddressBus`, `DataBus` and `RW` toward memory, waits a variable number of cycles for `MemReady`, and returns read data and completion to the owning port. A timeout counter converts a hung memory access into an error completion so the core never deadlocks.

## Interface
Parameters:
- `TIMEOUT`, default 16: cycles in BUSY without `MemReady` before an error completion; legal range 1..255.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `FetchReq` in 1: fetch port request (level, held until `FetchAck`).
- `FetchAddr` in 32: fetch address.
- `FetchAck` out 1: one-cycle completion pulse for fetch.
- `DataReq` in 1: data port request (level, held until `DataAck`).
- `DataRW` in 1: 1 = read (LDR), 0 = write (STR).
- `DataAddr` in 32: data address.
- `DataWData` in 32: store data.
- `DataAck` out 1: one-cycle completion pulse for data port.
- `RData` out 32: read data, valid while either Ack is high.
- `Err` out 1: high with Ack when the access timed out.
- `MemReq` out 1: bus cycle active.
- `AddressBus` out 32: memory address.
- `DataBus` out 32: memory write data.
- `RW` out 1: 1 = read, 0 = write. Fetch is always a read.
- `MemReady` in 1: memory completes the current access.
- `MemRData` in 32: memory read data, sampled when `MemReady` is high.

## Operation
- States: IDLE, BUSY, DONE; encoded 2 bits, reset to IDLE.
- IDLE:
  - If any Req is high, choose the winner.
  - Latch the winner's address into `AddressBus`, its write data into `DataBus` (0 for fetch), and its `RW`.
  - Record the owner, clear the timeout counter, set `MemReq` = 1, and go to BUSY.
  - If no Req is high, stay in IDLE.
- BUSY:
  - Bus outputs stay frozen.
  - If `MemReady` is high: capture `MemRData` into `RData` (write: `RData` = 0), `Err` = 0, and go to DONE.
  - Else, if counter = `TIMEOUT`-1: `RData` = 32'hDEADBEEF, `Err` = 1, and go to DONE.
  - Else increment the counter.
- DONE:
  - `MemReq` = 0; the owner's Ack = 1 for exactly this cycle.
  - Go to IDLE unconditionally.
- Requester changes to Req/Addr/WData while BUSY are ignored, because the values were latched at grant.
- Arbitration without the macro is fixed priority: data beats fetch when both are requesting.
- Ack semantics: a requester that still holds Req in the cycle after its Ack is treated as a new transaction.
- `MemReady` outside BUSY is ignored.
- Counter width is 8 bits; it never wraps, because the timeout fires first.

## Timing
- Reset values: `FetchAck` = `DataAck` = `Err` = `MemReq` = `RW` = 0, `AddressBus` = `DataBus` = `RData` = 0, counter 0, owner = fetch, round-robin last-owner = fetch.
- Req high at edge N (IDLE) → `MemReq`/bus valid after edge N.
- `MemReady` high at edge N+k (k ≥ 1) → Ack/`RData` valid after edge N+k for one cycle → IDLE after edge N+k+1.
- Minimum transfer is 3 cycles. Back-to-back throughput is one access per 3 + wait cycles.
- Timeout: Ack+`Err` appear after edge N+`TIMEOUT`.
- `MemReady` and timeout on the same edge: `MemReady` wins (`Err` = 0).
- `rst_n` low at any edge, including mid-BUSY or DONE, forces all reset values after that edge. The pending access is abandoned with no Ack.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`
  - Defined: on simultaneous requests in IDLE, grant the port that was NOT the last owner. The last-owner register updates at each grant. Reset value fetch means the first tie goes to data.
  - Undefined: fixed priority, data over fetch. The last-owner register is not built.

## Test plan
- Single fetch:
  - Stimulus: `FetchReq`=1, `FetchAddr`=32'h00000040, `MemReady` after 2 BUSY cycles with `MemRData`=32'hE3A01005.
  - Required: `MemReq`=1 and `RW`=1 for 2 cycles, then `FetchAck`=1 for 1 cycle with `RData`=32'hE3A01005 and `Err`=0.
- Store:
  - Stimulus: `DataReq`=1, `DataRW`=0, `DataAddr`=32'h12345678, `DataWData`=32'h9ABCDEF0, `MemReady` on first BUSY cycle.
  - Required: `AddressBus`/`DataBus` show those values with `RW`=0, then `DataAck`=1 and `RData`=0.
- Contention, both Reqs held:
  - Without macro: the grant order is data, data, …, and fetch is never served.
  - With `MEM_ARB_ROUND_ROBIN_EN`: the grant order is data, fetch, data, fetch.
- Timeout:
  - Stimulus: `TIMEOUT`=4, `MemReady` held 0.
  - Required: Ack with `Err`=1 and `RData`=32'hDEADBEEF exactly 4 cycles after `MemReq` rises.
  - Same-edge variant: `MemReady` on the 4th cycle gives `Err`=0.
- Reset mid-access:
  - Stimulus: `rst_n`=0 during BUSY for 1 cycle.
  - Required: all outputs 0 next cycle, no Ack, and a held Req is re-granted from IDLE after reset is released.
